decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode / register-read stage sitting directly upstream of the ALU.
- Accepts 32-bit MIPS-subset instructions from fetch, reads a 32x32 register file and sign-extends the immediate.
- Tracks pending register writes with a scoreboard and stalls on RAW hazards.
- Presents operands and decoded control to the execute stage through a registered valid/ready pipeline slot; accepts writeback from downstream.

Parameters:
- DATA_W, 32, operand/register width.
- REG_INIT, 0, reset value of every register-file entry.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- if_valid  input  1  fetch presents an instruction.
- if_inst  input  32  instruction word.
- if_ready  output  1  stage accepts if_inst this cycle.
- ex_valid  output  1  execute slot holds a valid decoded instruction.
- ex_ready  input  1  execute consumes the slot this cycle.
- ex_inst  output  32  registered copy of the accepted instruction.
- ex_op_a  output  DATA_W  value of rs.
- ex_op_b  output  DATA_W  value of rt.
- ex_imm  output  DATA_W  sign-extended inst[15:0].
- ex_alu_op  output  2  00 add, 01 sub, 10 slt.
- ex_mem_rd  output  1  load.
- ex_mem_wr  output  1  store.
- ex_reg_wr  output  1  instruction writes a register.
- ex_dst  output  5  destination register index.
- wb_en  input  1  writeback strobe.
- wb_addr  input  5  writeback register index.
- wb_data  input  DATA_W  writeback value.
- ill_inst  output  1  one-cycle pulse when an illegal instruction is consumed.

Behaviour:
- Reset (async, rst=1): all registers=REG_INIT, scoreboard cleared, ex_valid=0, all ex_* outputs=0, ill_inst=0. if_ready follows the combinational rule below. An in-flight slot is discarded.
- Decode:
  - opcode 000000 with funct 100000 → add; 100010 → sub; 101010 → slt. Sources rs,rt; dst=rd; reg_wr=1.
  - opcode 100011 (lw): alu add, mem_rd=1. Source rs; dst=rt; reg_wr=1.
  - opcode 101011 (sw): alu add, mem_wr=1. Sources rs,rt; reg_wr=0.
  - Any other opcode/funct is illegal.
- Register file:
  - Register 0 always reads 0; writes to 0 are ignored.
  - Write on posedge when wb_en=1.
  - Same-cycle bypass: a read of wb_addr (≠0) while wb_en=1 returns wb_data.
- Scoreboard: 32 busy bits; bit 0 is never set.
  - Set on accept of an instruction with reg_wr=1 and dst≠0.
  - Cleared on wb_en for wb_addr.
  - Set and clear to the same index in the same cycle: set wins.
- Hazard: a used source index has its busy bit set, and is not being cleared by wb_en this cycle. Unused sources are ignored (lw rt).
- Handshake:
  - if_ready = (!ex_valid | ex_ready) & !hazard.
  - Accept = if_valid & if_ready.
  - On accept of a legal instruction: load the slot, ex_valid=1, latency 1 cycle.
  - On accept of an illegal instruction: no scoreboard change, ill_inst=1 for one cycle. ex_valid becomes 0 if ex_ready=1, otherwise holds.
  - ex_valid & ex_ready without a new accept → ex_valid=0.
  - Slot contents are stable while ex_valid & !ex_ready.
  - Back-to-back full throughput when ex_ready is held high and there are no hazards.
- Operands are captured at accept. Later writebacks do not update an occupied slot.
- Immediate: {{16{inst[15]}}, inst[15:0]} (extended to DATA_W).

Test Plan:
- Reset, then issue add $3,$1,$2 with regs preloaded via wb ($1=5, $2=7) → next cycle ex_valid=1, op_a=5, op_b=7, alu_op=00, dst=3, reg_wr=1; busy[3]=1.
- Issue sub $4,$3,$1 right after add $3 with no wb → if_ready=0 (stall). Drive wb_en, addr 3, data 12 → accepted the same cycle with op_a=12 (bypass).
- Issue lw $5,-4($1), inst[15:0]=FFFC → ex_imm=FFFFFFFC, mem_rd=1, dst=5. Issue sw $5,8($2) while busy[5] is set → stall until wb to 5.
- Hold ex_ready=0 with the slot full → if_ready=0 and slot outputs unchanged for 3 cycles. Raise ex_ready → the next instruction enters the following cycle.
- Opcode 111111, then R-type funct 000111 → each raises ill_inst for one cycle, ex_valid stays 0, scoreboard unchanged. wb to $0 with data 0xDEAD → reads of $0 return 0.
- Assert rst while ex_valid=1 with busy bits set → ex_valid=0 and scoreboard clear immediately (before the next clock edge). After release, a new instruction is accepted with no stall.

Source files
------------

// File: rtl/decode_stage.sv
// Decode / register-read stage: decodes a MIPS subset, reads the register file,
// tracks pending writes with a busy scoreboard and hands a registered slot to execute.
module decode_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] REG_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_inst,
  output logic              if_ready,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_inst,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [1:0]        ex_alu_op,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_reg_wr,
  output logic [4:0]        ex_dst,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ill_inst
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;

  logic [DATA_W-1:0] regs [32];
  logic [31:0]       busy;
  logic [31:0]       busy_next;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  logic       dec_legal;
  logic [1:0] dec_alu_op;
  logic       dec_mem_rd;
  logic       dec_mem_wr;
  logic       dec_reg_wr;
  logic [4:0] dec_dst;
  logic       use_rs;
  logic       use_rt;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] imm_ext;
  logic              clr_rs;
  logic              clr_rt;
  logic              hazard;
  logic              accept;
  logic              load_slot;

  assign opcode = if_inst[31:26];
  assign rs     = if_inst[25:21];
  assign rt     = if_inst[20:16];
  assign rd     = if_inst[15:11];
  assign funct  = if_inst[5:0];

  // Illegal encodings claim no sources so they can never stall the front end.
  always_comb begin
    dec_legal  = 1'b0;
    dec_alu_op = ALU_ADD;
    dec_mem_rd = 1'b0;
    dec_mem_wr = 1'b0;
    dec_reg_wr = 1'b0;
    dec_dst    = 5'd0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            dec_legal  = 1'b1;
            dec_alu_op = ALU_ADD;
          end
          FN_SUB: begin
            dec_legal  = 1'b1;
            dec_alu_op = ALU_SUB;
          end
          FN_SLT: begin
            dec_legal  = 1'b1;
            dec_alu_op = ALU_SLT;
          end
          default: dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
          dec_reg_wr = 1'b1;
          dec_dst    = rd;
          use_rs     = 1'b1;
          use_rt     = 1'b1;
        end
      end
      OP_LW: begin
        dec_legal  = 1'b1;
        dec_alu_op = ALU_ADD;
        dec_mem_rd = 1'b1;
        dec_reg_wr = 1'b1;
        dec_dst    = rt;
        use_rs     = 1'b1;
      end
      OP_SW: begin
        dec_legal  = 1'b1;
        dec_alu_op = ALU_ADD;
        dec_mem_wr = 1'b1;
        use_rs     = 1'b1;
        use_rt     = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // A same-cycle writeback is forwarded so the instruction sees the value being written.
  assign rd_a = (rs == 5'd0) ? '0 :
                (wb_en && (wb_addr == rs)) ? wb_data : regs[rs];
  assign rd_b = (rt == 5'd0) ? '0 :
                (wb_en && (wb_addr == rt)) ? wb_data : regs[rt];

  assign imm_ext = {{(DATA_W-16){if_inst[15]}}, if_inst[15:0]};

  assign clr_rs = wb_en && (wb_addr == rs);
  assign clr_rt = wb_en && (wb_addr == rt);
  assign hazard = (use_rs && busy[rs] && !clr_rs) ||
                  (use_rt && busy[rt] && !clr_rt);

  assign if_ready  = (!ex_valid || ex_ready) && !hazard;
  assign accept    = if_valid && if_ready;
  assign load_slot = accept && dec_legal;

  // Clear is applied before set so a new producer wins over a retiring one.
  always_comb begin
    busy_next = busy;
    if (wb_en) begin
      busy_next[wb_addr] = 1'b0;
    end
    if (load_slot && dec_reg_wr && (dec_dst != 5'd0)) begin
      busy_next[dec_dst] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= REG_INIT;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Slot contents only change on a legal accept, so they stay put while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_inst   <= '0;
      ex_op_a   <= '0;
      ex_op_b   <= '0;
      ex_imm    <= '0;
      ex_alu_op <= 2'b00;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_reg_wr <= 1'b0;
      ex_dst    <= 5'd0;
      ill_inst  <= 1'b0;
    end else begin
      ill_inst <= accept && !dec_legal;
      if (load_slot) begin
        ex_valid  <= 1'b1;
        ex_inst   <= if_inst;
        ex_op_a   <= rd_a;
        ex_op_b   <= rd_b;
        ex_imm    <= imm_ext;
        ex_alu_op <= dec_alu_op;
        ex_mem_rd <= dec_mem_rd;
        ex_mem_wr <= dec_mem_wr;
        ex_reg_wr <= dec_reg_wr;
        ex_dst    <= dec_dst;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a reference model predicts each slot at accept
// time into a queue that is compared whenever the slot is presented to execute.
module tb_decode_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_valid = 1'b0;
  logic [31:0]       if_inst = '0;
  logic              if_ready;
  logic              ex_valid;
  logic              ex_ready = 1'b0;
  logic [31:0]       ex_inst;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [DATA_W-1:0] ex_imm;
  logic [1:0]        ex_alu_op;
  logic              ex_mem_rd;
  logic              ex_mem_wr;
  logic              ex_reg_wr;
  logic [4:0]        ex_dst;
  logic              wb_en = 1'b0;
  logic [4:0]        wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              ill_inst;

  decode_stage #(.DATA_W(DATA_W), .REG_INIT('0)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_reg_wr(ex_reg_wr), .ex_dst(ex_dst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ill_inst(ill_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [1:0]  alu;
    logic        mrd;
    logic        mwr;
    logic        rwr;
    logic [4:0]  dst;
  } slot_t;

  slot_t       exp_q[$];
  logic [31:0] shadow [32];
  logic [31:0] busy_m;
  bit          exp_valid;
  bit          exp_ill;
  int          n_vec;
  int          n_err;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'b000000, s, t, d, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return shadow[idx];
  endfunction

  task automatic model_decode(input logic [31:0] inst, output bit legal, output logic [1:0] alu,
                              output logic mrd, output logic mwr, output logic rwr,
                              output logic [4:0] dst, output bit ura, output bit urb);
    legal = 0; alu = 2'b00; mrd = 0; mwr = 0; rwr = 0; dst = 5'd0; ura = 0; urb = 0;
    if (inst[31:26] == 6'b000000 &&
        (inst[5:0] == 6'h20 || inst[5:0] == 6'h22 || inst[5:0] == 6'h2a)) begin
      legal = 1; rwr = 1; dst = inst[15:11]; ura = 1; urb = 1;
      alu = (inst[5:0] == 6'h20) ? 2'b00 : (inst[5:0] == 6'h22) ? 2'b01 : 2'b10;
    end else if (inst[31:26] == 6'b100011) begin
      legal = 1; mrd = 1; rwr = 1; dst = inst[20:16]; ura = 1;
    end else if (inst[31:26] == 6'b101011) begin
      legal = 1; mwr = 1; ura = 1; urb = 1;
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_valid = 0;
    exp_ill   = 0;
    busy_m    = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
  endtask

  // One clock of stimulus: drive, check at the falling edge, advance the model.
  task automatic apply_stimulus(input string tag, input logic v, input logic [31:0] inst,
                                input logic rdy, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd);
    slot_t       s;
    bit          legal, ura, urb, haz, rdy_exp, acc;
    logic [1:0]  alu;
    logic        mrd, mwr, rwr;
    logic [4:0]  dst, rs, rt;
    if_valid = v; if_inst = inst; ex_ready = rdy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    model_decode(inst, legal, alu, mrd, mwr, rwr, dst, ura, urb);
    rs = inst[25:21];
    rt = inst[20:16];
    haz = (ura && busy_m[rs] && !(we && wa == rs)) || (urb && busy_m[rt] && !(we && wa == rt));
    rdy_exp = (!exp_valid || rdy) && !haz;
    check_output({tag, ".if_ready"}, {31'd0, if_ready}, {31'd0, rdy_exp});
    check_output({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, exp_valid});
    check_output({tag, ".ill_inst"}, {31'd0, ill_inst}, {31'd0, exp_ill});
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        check_output({tag, ".queue_nonempty"}, 32'd0, 32'd1);
      end else begin
        s = exp_q[0];
        check_output({tag, ".ex_inst"}, ex_inst, s.inst);
        check_output({tag, ".ex_op_a"}, ex_op_a, s.a);
        check_output({tag, ".ex_op_b"}, ex_op_b, s.b);
        check_output({tag, ".ex_imm"}, ex_imm, s.imm);
        check_output({tag, ".ex_alu_op"}, {30'd0, ex_alu_op}, {30'd0, s.alu});
        check_output({tag, ".ex_mem_rd"}, {31'd0, ex_mem_rd}, {31'd0, s.mrd});
        check_output({tag, ".ex_mem_wr"}, {31'd0, ex_mem_wr}, {31'd0, s.mwr});
        check_output({tag, ".ex_reg_wr"}, {31'd0, ex_reg_wr}, {31'd0, s.rwr});
        if (s.rwr) check_output({tag, ".ex_dst"}, {27'd0, ex_dst}, {27'd0, s.dst});
        if (rdy) void'(exp_q.pop_front());
      end
    end
    acc = v && rdy_exp;
    if (acc && legal) begin
      s.inst = inst;
      s.a    = read_model(rs, we, wa, wd);
      s.b    = read_model(rt, we, wa, wd);
      s.imm  = {{16{inst[15]}}, inst[15:0]};
      s.alu  = alu; s.mrd = mrd; s.mwr = mwr; s.rwr = rwr; s.dst = dst;
      exp_q.push_back(s);
      exp_valid = 1;
    end else if (rdy) begin
      exp_valid = 0;
    end
    exp_ill = acc && !legal;
    if (we) busy_m[wa] = 1'b0;
    if (acc && legal && rwr && dst != 5'd0) busy_m[dst] = 1'b1;
    busy_m[0] = 1'b0;
    if (we && wa != 5'd0) shadow[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] add3, sub4, lw5, sw5, add6, add12, add14;
    n_vec = 0;
    n_err = 0;
    reset_model();
    add3  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    sub4  = rtype(5'd3, 5'd1, 5'd4, 6'h22);
    lw5   = itype(6'b100011, 5'd1, 5'd5, 16'hFFFC);
    sw5   = itype(6'b101011, 5'd2, 5'd5, 16'h0008);
    add6  = rtype(5'd1, 5'd2, 5'd6, 6'h20);
    add12 = rtype(5'd6, 5'd7, 5'd12, 6'h20);
    add14 = rtype(5'd12, 5'd0, 5'd14, 6'h20);

    #1 rst = 1'b1;
    #2;
    check_output("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_output("reset.ill_inst", {31'd0, ill_inst}, 32'd0);
    check_output("reset.ex_inst", ex_inst, 32'd0);
    check_output("reset.ex_op_a", ex_op_a, 32'd0);
    check_output("reset.if_ready", {31'd0, if_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    apply_stimulus("preload1", 0, 32'd0, 1, 1, 5'd1, 32'd5);
    apply_stimulus("preload2", 0, 32'd0, 1, 1, 5'd2, 32'd7);
    apply_stimulus("add3", 1, add3, 1, 0, 5'd0, 32'd0);
    apply_stimulus("sub4_stall", 1, sub4, 1, 0, 5'd0, 32'd0);
    apply_stimulus("sub4_bypass", 1, sub4, 1, 1, 5'd3, 32'd12);
    apply_stimulus("lw5", 1, lw5, 1, 0, 5'd0, 32'd0);
    apply_stimulus("sw5_stall1", 1, sw5, 1, 0, 5'd0, 32'd0);
    apply_stimulus("sw5_stall2", 1, sw5, 1, 0, 5'd0, 32'd0);
    apply_stimulus("sw5_wb", 1, sw5, 1, 1, 5'd5, 32'd99);

    for (int i = 0; i < 3; i++) apply_stimulus("hold", 1, add6, 0, 0, 5'd0, 32'd0);
    apply_stimulus("release", 1, add6, 1, 0, 5'd0, 32'd0);
    apply_stimulus("drain1", 0, 32'd0, 1, 0, 5'd0, 32'd0);

    apply_stimulus("ill_op", 1, {6'b111111, 26'd0}, 1, 0, 5'd0, 32'd0);
    apply_stimulus("ill_fn", 1, rtype(5'd1, 5'd2, 5'd3, 6'b000111), 1, 0, 5'd0, 32'd0);
    apply_stimulus("ill_idle", 0, 32'd0, 1, 0, 5'd0, 32'd0);
    apply_stimulus("wb_r0", 0, 32'd0, 1, 1, 5'd0, 32'hDEAD);
    apply_stimulus("read_r0_wb", 1, rtype(5'd0, 5'd0, 5'd7, 6'h20), 1, 1, 5'd0, 32'hDEAD);
    apply_stimulus("read_r0", 1, rtype(5'd0, 5'd0, 5'd7, 6'h2a), 1, 0, 5'd0, 32'd0);

    apply_stimulus("b2b_1", 1, rtype(5'd1, 5'd2, 5'd8, 6'h20), 1, 0, 5'd0, 32'd0);
    apply_stimulus("b2b_2", 1, rtype(5'd2, 5'd1, 5'd9, 6'h22), 1, 0, 5'd0, 32'd0);
    apply_stimulus("b2b_3", 1, rtype(5'd1, 5'd1, 5'd10, 6'h2a), 1, 0, 5'd0, 32'd0);
    apply_stimulus("lw11", 1, itype(6'b100011, 5'd1, 5'd11, 16'h0010), 0, 0, 5'd0, 32'd0);

    if_valid = 1'b1; if_inst = add12; ex_ready = 1'b0; wb_en = 1'b0;
    rst = 1'b1;
    #1;
    check_output("midrst.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_output("midrst.ex_inst", ex_inst, 32'd0);
    check_output("midrst.ex_op_a", ex_op_a, 32'd0);
    check_output("midrst.ex_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    check_output("midrst.if_ready", {31'd0, if_ready}, 32'd1);
    reset_model();
    @(posedge clk);
    #1 rst = 1'b0;

    apply_stimulus("post_rst_add12", 1, add12, 1, 1, 5'd12, 32'd1);
    apply_stimulus("set_wins_stall", 1, add14, 1, 0, 5'd0, 32'd0);
    apply_stimulus("set_wins_wb", 1, add14, 1, 1, 5'd12, 32'd33);
    apply_stimulus("final_idle", 0, 32'd0, 1, 0, 5'd0, 32'd0);
    check_output("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
